// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl -- multiply/divide unit with sequencing control for the P6 MIPS core
//
// Sits beside the ALU in EX. It accepts mult/multu/div/divu/mthi/mtlo, owns
// the architectural HI/LO registers, and raises Busy for the multi-cycle
// latency so the hazard unit can stall dependent mfhi/mflo and MD ops.
//
// The arithmetic is a single combinational multiply/divide on the latched
// operands, captured into HI/LO on the last Busy edge. Only the cycle-level
// Busy and HI/LO timing is meant to be observed.
//
// Parameters:
//   MULT_CYCLES  Busy length for mult/multu, 1..15 (default 5)
//   DIV_CYCLES   Busy length for div/divu,   1..15 (default 10)
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   Start   in   1   command valid; MDUOp/SrcA/SrcB sampled on that edge
//   MDUOp   in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none
//   SrcA    in  32   rs operand (dividend / multiplicand / mthi-mtlo data)
//   SrcB    in  32   rt operand (divisor / multiplier)
//   Cancel  in   1   only when MDU_CANCEL_EN is defined: exception flush
//   Busy    out  1   high while a mult/div is in flight
//   HI      out 32   architectural HI register
//   LO      out 32   architectural LO register
//
// Optional feature macro: MDU_CANCEL_EN
//   Defined     -> Cancel port exists. Cancel while BUSY aborts the operation
//                  (HI/LO untouched); Cancel while IDLE drops a same-cycle
//                  Start. Cancel beats completion in the same cycle.
//   Not defined -> no Cancel port, operations always run to completion.
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
`ifdef MDU_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // ------------------------------------------------------------------
    // Opcodes and counter load values
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [2:0]  op_q,    op_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = Cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath on the latched operands
    // ------------------------------------------------------------------
    logic        is_div;
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_by_zero;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

    // The low 64 bits of a 64x64 product are the same for signed and
    // unsigned operands, so sign/zero extension alone selects mult vs multu.
    assign ext_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = ext_a * ext_b;

    // Signed divide is done on magnitudes and the signs re-applied. This
    // keeps 0x80000000 / -1 well defined: magnitude 0x80000000 / 1 gives
    // quotient 0x80000000 with remainder 0, which is the required result.
    assign a_neg       = is_signed & a_q[31];
    assign b_neg       = is_signed & b_q[31];
    assign a_mag       = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag       = b_neg ? (32'd0 - b_q) : b_q;
    assign div_by_zero = (b_q == 32'd0);
    // The divider never sees zero; the result is discarded in that case.
    assign b_safe      = div_by_zero ? 32'd1 : b_mag;
    assign q_mag       = a_mag / b_safe;
    assign r_mag       = a_mag % b_safe;
    assign quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem         = a_neg ? (32'd0 - r_mag) : r_mag;

    assign res_hi = is_div ? rem  : prod[63:32];
    assign res_lo = is_div ? quot : prod[31:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                // Cancel outranks Start: a flushed command must not issue.
                if (Start && !cancel_w) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            a_d     = SrcA;
                            b_d     = SrcB;
                            op_d    = MDUOp;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = SrcA;
                            b_d     = SrcB;
                            op_d    = MDUOp;
                            cnt_d   = DIV_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = SrcA;
                        OP_MTLO: lo_d = SrcA;
                        default: ;  // none / reserved
                    endcase
                end
            end

            S_BUSY: begin
                // Start is ignored here; only cancel or the count matter.
                if (cancel_w) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    // Last Busy edge: commit the result and drop Busy.
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (!(is_div && div_by_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= OP_NONE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl
//
// Directed sequence in one initial block. Each mult/div pushes its expected
// HI/LO/Busy length (from a small behavioural model) to a scoreboard queue
// when driven; the entry is popped and compared when Busy falls.
// Cancel tests are compiled only when MDU_CANCEL_EN is defined.
// ============================================================================
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
`ifdef MDU_CANCEL_EN
    logic        Cancel;
`endif
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
`ifdef MDU_CANCEL_EN
        .Cancel(Cancel),
`endif
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors;
    int          miscompares;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model of HI/LO after an accepted command.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(sa * sb);
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                sr = sa / sb;
                p  = 64'(sr);
                lo_m = p[31:0];
                sr = sa % sb;
                p  = 64'(sr);
                hi_m = p[31:0];
            end
            3'd4: if (b != 32'd0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue a mult/div, scramble the operand inputs during Busy, measure
    // the Busy length and compare HI/LO against the scoreboard entry.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        exp_t        e;
        int          n;
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        hi_prev  = hi_m;
        lo_prev  = lo_m;
        model_op(op, a, b);
        e.hi     = hi_m;
        e.lo     = lo_m;
        e.cycles = (op <= 3'd2) ? MULT_N : DIV_N;
        sb_q.push_back(e);

        @(negedge clk);
        Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = 3'd0; SrcA = $urandom; SrcB = $urandom;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            if (n == e.cycles - 1) begin
                check({tag, "_early_hi"}, HI, hi_prev);
                check({tag, "_early_lo"}, LO, lo_prev);
            end
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        check({tag, "_busy_len"}, 32'(n), 32'(e.cycles));
        check({tag, "_hi"}, HI, e.hi);
        check({tag, "_lo"}, LO, e.lo);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a, input string tag);
        @(negedge clk);
        Start = 1'b1; MDUOp = op; SrcA = a; SrcB = 32'd0;
        model_op(op, a, 32'd0);
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = 3'd0;
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
    endtask

    initial begin
        exp_t        e;
        int          n;
        logic [31:0] ra;
        logic [31:0] rb;

        vectors = 0; miscompares = 0;
        hi_m = 32'd0; lo_m = 32'd0;
        reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
`ifdef MDU_CANCEL_EN
        Cancel = 1'b0;
`endif
        // --- reset state ---
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk); reset = 1'b0;

        // --- mthi then mtlo on consecutive cycles ---
        move_to(3'd5, 32'h12345678, "mthi");
        move_to(3'd6, 32'h9ABCDEF0, "mtlo");
        check("mthi_plan", HI, 32'h12345678);
        check("mtlo_plan", LO, 32'h9ABCDEF0);

        // --- plan arithmetic ---
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, "mult_neg2x3");
        check("mult_plan_hi", HI, 32'hFFFFFFFF);
        check("mult_plan_lo", LO, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFFF, 32'd2, "multu_max_x2");
        check("multu_plan_hi", HI, 32'h00000001);
        check("multu_plan_lo", LO, 32'hFFFFFFFE);

        run_op(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
        check("div_plan_lo", LO, 32'hFFFFFFFD);
        check("div_plan_hi", HI, 32'hFFFFFFFF);

        move_to(3'd5, 32'h00000011, "pre_hi");
        move_to(3'd6, 32'h00000022, "pre_lo");
        run_op(3'd4, 32'd7, 32'd0, "divu_by_zero");
        check("divz_plan_hi", HI, 32'h00000011);
        check("divz_plan_lo", LO, 32'h00000022);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
        check("divovf_plan_lo", LO, 32'h80000000);
        check("divovf_plan_hi", HI, 32'h00000000);

        run_op(3'd3, 32'd100, 32'hFFFFFFF9, "div_100_neg7");
        run_op(3'd4, 32'hFFFFFFF0, 32'd7, "divu_big_7");

        // --- Start (mult, then mthi) while busy is ignored ---
        model_op(3'd1, 32'd1000, 32'd1000);
        e.hi = hi_m; e.lo = lo_m; e.cycles = MULT_N;
        sb_q.push_back(e);
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd1; SrcA = 32'd1000; SrcB = 32'd1000;
        @(posedge clk); #1;
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (n == 1) begin
                Start = 1'b1; MDUOp = 3'd1; SrcA = 32'd7; SrcB = 32'd9;
            end else if (n == 2) begin
                Start = 1'b1; MDUOp = 3'd5; SrcA = 32'hDEADBEEF;
            end else begin
                Start = 1'b0; MDUOp = 3'd0;
            end
            @(posedge clk); #1;
            n++;
        end
        Start = 1'b0; MDUOp = 3'd0;
        e = sb_q.pop_front();
        check("busy_start_len", 32'(n), 32'(e.cycles));
        check("busy_start_hi", HI, e.hi);
        check("busy_start_lo", LO, e.lo);
        @(posedge clk); #1;
        check("busy_start_no_restart", 32'(Busy), 32'd0);

        // --- ops 0 and 7 do nothing ---
        move_to(3'd0, 32'hCAFEF00D, "op_none");
        move_to(3'd7, 32'hCAFEF00D, "op_reserved");

        // --- asynchronous reset during cycle 2 of a mult ---
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd1; SrcA = 32'd12345; SrcB = 32'd678;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = 3'd0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("arst_stays_hi", HI, 32'd0);
        run_op(3'd1, 32'hFFFF0000, 32'h00010001, "mult_after_reset");

        // --- random mix against the model ---
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 1) ? $urandom : {$urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'h0,
                                             8'($urandom_range(1, 200))};
            run_op(3'(1 + (i % 4)), ra, rb, $sformatf("rand%0d", i));
        end

`ifdef MDU_CANCEL_EN
        // --- cancel during cycle 4 of a div ---
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd3; SrcA = 32'd100; SrcB = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); Cancel = 1'b1;
        @(posedge clk); #1;
        Cancel = 1'b0;
        check("cancel_busy", 32'(Busy), 32'd0);
        check("cancel_hi", HI, hi_m);
        check("cancel_lo", LO, lo_m);
        repeat (10) @(posedge clk);
        #1;
        check("cancel_no_late_hi", HI, hi_m);

        // --- cancel together with Start in IDLE ---
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd1; SrcA = 32'd3; SrcB = 32'd4; Cancel = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Cancel = 1'b0;
        check("cancel_start_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd5; SrcA = 32'h55AA55AA; Cancel = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Cancel = 1'b0;
        check("cancel_mthi_hi", HI, hi_m);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit with sequencing control for the P6 pipelined MIPS core. It sits beside the ALU in the EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo commands.
- Models the multi-cycle latency with a counter-driven state machine.
- Owns the architectural HI/LO registers.
- Exposes Busy so the hazard unit can stall dependent mfhi/mflo and MD instructions.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (legal range 1..15)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  command valid for one cycle; MDUOp/SrcA/SrcB are sampled on the edge where Start=1
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
SrcA  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
SrcB  input  32  rt operand (divisor / multiplier)
Busy  output  1  1 while a mult/div is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
Cancel  input  1  present only with MDU_CANCEL_EN (see below)

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, Busy=0, HI=0, LO=0, counter=0, operand latches=0. Any in-flight operation is discarded.
- States and transitions:
  - IDLE: on Start=1 with MDUOp in 1..4, latch SrcA, SrcB and the op. Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4). Go to BUSY.
  - BUSY: counter decrements each edge. On the edge where counter would reach 0, write HI/LO with the result and return to IDLE.
- Busy timing: Busy is registered and equals (state==BUSY). Busy goes high on the edge after the Start edge and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES). HI/LO update on the same edge Busy falls. Results are visible the cycle after Busy falls.
- mthi/mtlo: on Start=1 in IDLE, SrcA is written to HI (op 5) or LO (op 6) on that edge. Busy stays 0.
- Start while BUSY: ignored entirely; no operand latch, no HI/LO write. The hazard unit guarantees this does not occur, but the block must tolerate it.
- Start with op 0 or 7: no effect.
- Arithmetic, computed on the latched operands; SrcA/SrcB changing during BUSY has no effect:
  - mult: signed 32x32 to 64-bit product; HI=prod[63:32], LO=prod[31:0].
  - multu: same, unsigned.
  - div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
- Divide by zero: the full DIV_CYCLES Busy period still elapses; HI and LO are left unchanged.
- The result may be a single combinational multiply/divide captured at the end; only the cycle-level Busy and HI/LO timing is normative.

Optional Feature:
Macro MDU_CANCEL_EN.
- Defined: adds input Cancel (1 bit). When Cancel=1 at an edge while BUSY, go to IDLE with Busy=0 on that edge; HI/LO keep their pre-operation values. Cancel has priority over completion in the same cycle. Cancel in IDLE has priority over Start, so that command is dropped. Used for exception flush.
- Not defined: the Cancel port does not exist and operations always run to completion.

Test Plan:
- Reset pulse mid-mult (cycle 2 of 5) -> Busy=0, HI=0, LO=0 immediately (asynchronously); a subsequent Start works normally.
- mult SrcA=0xFFFFFFFE (-2), SrcB=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu SrcA=0xFFFFFFFF, SrcB=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Also change SrcA/SrcB during Busy -> result unaffected.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy high exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with HI=0x11, LO=0x22 preloaded -> Busy 10 cycles, HI/LO unchanged.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each edge, Busy stays 0. A mult Start issued on the 2nd Busy cycle of a prior mult is ignored: only the first result is written, and Busy falls after 5 cycles total.
- (MDU_CANCEL_EN) div 100/7 with Cancel=1 on cycle 4 -> Busy=0 next edge, HI/LO keep their pre-div values. Cancel and Start together in IDLE -> no operation starts.
